// File: rtl/diffeq_solver_param_if.sv
// -----------------------------------------------------------------------------
// diffeq_solver_param_if
//
// Purpose:
//   Groups the start/done handshake and the operand/result buses of the
//   diffeq_solver_param compute kernel. The controller holds the master side
//   and the kernel holds the slave side.
//
// Parameters:
//   WIDTH      datapath width of x/y/u/a/dx and all results
//   MAX_STEPS  iteration limit of the kernel (sets the step counter width)
//
// Signals (direction seen from the kernel / slave side):
//   start      in   begin a run; sampled only while the kernel is idle
//   x_in       in   initial x
//   y_in       in   initial y
//   u_in       in   initial u
//   a_in       in   x upper bound (the kernel loops while x < a)
//   dx_in      in   step size
//   busy       out  high while a run is in progress
//   done       out  one-cycle pulse when the results are valid
//   timeout    out  last run was cut off by the iteration limit
//   x_out      out  final x
//   y_out      out  final y
//   u_out      out  final u
//   steps_out  out  number of steps taken in the last run
// -----------------------------------------------------------------------------
interface diffeq_solver_param_if #(
  parameter int WIDTH     = 32,
  parameter int MAX_STEPS = 1024
);
  localparam int STEP_W = $clog2(MAX_STEPS + 1);

  logic              start;
  logic [WIDTH-1:0]  x_in;
  logic [WIDTH-1:0]  y_in;
  logic [WIDTH-1:0]  u_in;
  logic [WIDTH-1:0]  a_in;
  logic [WIDTH-1:0]  dx_in;
  logic              busy;
  logic              done;
  logic              timeout;
  logic [WIDTH-1:0]  x_out;
  logic [WIDTH-1:0]  y_out;
  logic [WIDTH-1:0]  u_out;
  logic [STEP_W-1:0] steps_out;

  modport master (
    output start, x_in, y_in, u_in, a_in, dx_in,
    input  busy, done, timeout, x_out, y_out, u_out, steps_out
  );

  modport slave (
    input  start, x_in, y_in, u_in, a_in, dx_in,
    output busy, done, timeout, x_out, y_out, u_out, steps_out
  );
endinterface

// File: rtl/diffeq_solver_param.sv
// -----------------------------------------------------------------------------
// diffeq_solver_param
//
// Purpose:
//   Forward-Euler integrator for u'' + 3xu' + 3y = 0, one Euler step per
//   clock. A run is launched by a start pulse while idle: the operands are
//   latched, the kernel steps while x < a and the step count is below
//   MAX_STEPS, then it publishes x/y/u, the step count and a timeout flag and
//   pulses done for one cycle.
//
//   Per step, with t = u*dx (all arithmetic modulo 2^WIDTH):
//     u <= u - t*3*x - dx*3*y
//     y <= y + t
//     x <= x + dx
//
// Parameters:
//   WIDTH      datapath width (default 32)
//   MAX_STEPS  maximum Euler steps per run before forced termination (>= 1)
//
// Configuration macro:
//   DIFFEQ_SIGNED_COMPARE_EN  when defined, the x < a termination test and the
//                             timeout evaluation use a two's-complement signed
//                             compare; otherwise the compare is unsigned.
//                             Arithmetic results are identical in both builds.
//
// Ports:
//   clk    in     clock, all logic on the rising edge
//   reset  in     synchronous, active-high reset (priority over start)
//   bus    slave  handshake, operand and result signals
//                 (see diffeq_solver_param_if)
// -----------------------------------------------------------------------------
module diffeq_solver_param #(
  parameter int WIDTH     = 32,
  parameter int MAX_STEPS = 1024
) (
  input  logic                  clk,
  input  logic                  reset,
  diffeq_solver_param_if.slave  bus
);

  localparam int STEP_W = $clog2(MAX_STEPS + 1);

  localparam logic [WIDTH-1:0]  THREE   = WIDTH'(3);
  localparam logic [STEP_W-1:0] MAX_CNT = STEP_W'(MAX_STEPS);
  localparam logic [STEP_W-1:0] CNT_ONE = STEP_W'(1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t state_q;

  // Handshake / status registers (drive the outputs directly)
  logic              busy_q;
  logic              done_q;
  logic              timeout_q;

  // Latched operands and running state of the integration
  logic [WIDTH-1:0]  x_q;
  logic [WIDTH-1:0]  y_q;
  logic [WIDTH-1:0]  u_q;
  logic [WIDTH-1:0]  a_q;
  logic [WIDTH-1:0]  dx_q;
  logic [STEP_W-1:0] cnt_q;

  // Published results of the last completed run
  logic [WIDTH-1:0]  x_out_q;
  logic [WIDTH-1:0]  y_out_q;
  logic [WIDTH-1:0]  u_out_q;
  logic [STEP_W-1:0] steps_q;

  // Next values of one Euler step
  logic [WIDTH-1:0]  t;
  logic [WIDTH-1:0]  x_d;
  logic [WIDTH-1:0]  y_d;
  logic [WIDTH-1:0]  u_d;
  logic [STEP_W-1:0] cnt_d;
  logic              x_lt_a;
  logic              step_en;

  // Termination compare. Only the ordering changes between builds; the
  // add/sub/multiply datapath is the same modulo-2^WIDTH logic either way.
  function automatic logic lt_cmp(input logic [WIDTH-1:0] lhs,
                                  input logic [WIDTH-1:0] rhs);
`ifdef DIFFEQ_SIGNED_COMPARE_EN
    return $signed(lhs) < $signed(rhs);
`else
    return lhs < rhs;
`endif
  endfunction

  // Euler step datapath. Every product and sum is truncated to WIDTH bits,
  // so signed and unsigned interpretations give the same bit patterns.
  always_comb begin
    t       = u_q * dx_q;
    u_d     = u_q - (t * THREE * x_q) - (dx_q * THREE * y_q);
    y_d     = y_q + t;
    x_d     = x_q + dx_q;
    cnt_d   = cnt_q + CNT_ONE;
    x_lt_a  = lt_cmp(x_q, a_q);
    step_en = x_lt_a && (cnt_q < MAX_CNT);
  end

  // Control FSM and all registers. Reset clears the data registers too, so a
  // reset mid-run leaves zeroed results and no done pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      x_q       <= '0;
      y_q       <= '0;
      u_q       <= '0;
      a_q       <= '0;
      dx_q      <= '0;
      cnt_q     <= '0;
      x_out_q   <= '0;
      y_out_q   <= '0;
      u_out_q   <= '0;
      steps_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          // done is a single-cycle pulse; the results and timeout hold.
          done_q <= 1'b0;
          if (bus.start) begin
            x_q     <= bus.x_in;
            y_q     <= bus.y_in;
            u_q     <= bus.u_in;
            a_q     <= bus.a_in;
            dx_q    <= bus.dx_in;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end

        RUN: begin
          // start is not looked at here: requests while busy are dropped.
          if (step_en) begin
            x_q   <= x_d;
            y_q   <= y_d;
            u_q   <= u_d;
            cnt_q <= cnt_d;
          end else begin
            x_out_q   <= x_q;
            y_out_q   <= y_q;
            u_out_q   <= u_q;
            steps_q   <= cnt_q;
            // Still below the bound means the iteration limit ended the run.
            timeout_q <= x_lt_a;
            done_q    <= 1'b1;
            busy_q    <= 1'b0;
            state_q   <= IDLE;
          end
        end

        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.timeout   = timeout_q;
  assign bus.x_out     = x_out_q;
  assign bus.y_out     = y_out_q;
  assign bus.u_out     = u_out_q;
  assign bus.steps_out = steps_q;

endmodule

// File: tb/tb_diffeq_solver_param.sv
// -----------------------------------------------------------------------------
// tb_diffeq_solver_param
//
// Self-checking bench for diffeq_solver_param (WIDTH=32, MAX_STEPS=4).
// A behavioural model computes each run's result with a plain loop when the
// run is accepted and counts down the cycles until done; a compare process
// checks every DUT output against it on each falling edge. Directed scenarios
// add literal expectations; randomized runs follow.
// -----------------------------------------------------------------------------
module tb_diffeq_solver_param;

  localparam int WIDTH     = 32;
  localparam int MAX_STEPS = 4;
  localparam int STEP_W    = $clog2(MAX_STEPS + 1);

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  diffeq_solver_param_if #(.WIDTH(WIDTH), .MAX_STEPS(MAX_STEPS)) dif ();

  diffeq_solver_param #(.WIDTH(WIDTH), .MAX_STEPS(MAX_STEPS)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (dif)
  );

  int vectors     = 0;
  int miscompares = 0;

  // ---------------- behavioural model ----------------
  bit              m_busy = 1'b0;
  bit              m_done = 1'b0;
  bit              m_timeout = 1'b0;
  bit [WIDTH-1:0]  m_x = '0;
  bit [WIDTH-1:0]  m_y = '0;
  bit [WIDTH-1:0]  m_u = '0;
  bit [STEP_W-1:0] m_steps = '0;
  int              m_left = 0;

  bit [WIDTH-1:0]  r_x, r_y, r_u;
  int              r_steps;
  bit              r_to;

  function automatic bit lt(input bit [WIDTH-1:0] l, input bit [WIDTH-1:0] r);
`ifdef DIFFEQ_SIGNED_COMPARE_EN
    return $signed(l) < $signed(r);
`else
    return l < r;
`endif
  endfunction

  // Whole run in one go: iterate the Euler update until x >= a or the limit.
  task automatic run_model(input bit [WIDTH-1:0] x, input bit [WIDTH-1:0] y,
                           input bit [WIDTH-1:0] u, input bit [WIDTH-1:0] a,
                           input bit [WIDTH-1:0] dx);
    bit [WIDTH-1:0] t, un;
    int n;
    n = 0;
    while (lt(x, a) && n < MAX_STEPS) begin
      t  = u * dx;
      un = u - t * 32'd3 * x - dx * 32'd3 * y;
      y  = y + t;
      x  = x + dx;
      u  = un;
      n++;
    end
    r_x = x; r_y = y; r_u = u; r_steps = n; r_to = lt(x, a);
  endtask

  always @(posedge clk) begin
    if (reset) begin
      m_busy = 0; m_done = 0; m_timeout = 0;
      m_x = '0; m_y = '0; m_u = '0; m_steps = '0; m_left = 0;
    end else if (!m_busy) begin
      m_done = 0;
      if (dif.start) begin
        run_model(dif.x_in, dif.y_in, dif.u_in, dif.a_in, dif.dx_in);
        m_left = r_steps + 1;   // steps plus the terminating RUN cycle
        m_busy = 1;
      end
    end else begin
      m_left--;
      if (m_left == 0) begin
        m_busy = 0; m_done = 1; m_timeout = r_to;
        m_x = r_x; m_y = r_y; m_u = r_u; m_steps = STEP_W'(r_steps);
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    logic [3*WIDTH+STEP_W+2:0] act, exp;
    act = {dif.busy, dif.done, dif.timeout, dif.x_out, dif.y_out, dif.u_out, dif.steps_out};
    exp = {m_busy, m_done, m_timeout, m_x, m_y, m_u, m_steps};
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL cycle t=%0t: busy/done/to/x/y/u/steps actual=%b/%b/%b/%h/%h/%h/%0d expected=%b/%b/%b/%h/%h/%h/%0d",
               $time, dif.busy, dif.done, dif.timeout, dif.x_out, dif.y_out, dif.u_out, dif.steps_out,
               m_busy, m_done, m_timeout, m_x, m_y, m_u, m_steps);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic check(input string name, input logic [WIDTH-1:0] act,
                       input logic [WIDTH-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic load(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                      input logic [WIDTH-1:0] u, input logic [WIDTH-1:0] a,
                      input logic [WIDTH-1:0] dx);
    dif.x_in = x; dif.y_in = y; dif.u_in = u; dif.a_in = a; dif.dx_in = dx;
  endtask

  // Pulse start for one edge, then scramble the operands mid-run.
  task automatic go();
    dif.start = 1'b1;
    @(negedge clk);
    dif.start = 1'b0;
    load($urandom, $urandom, $urandom, $urandom, $urandom);
  endtask

  // Returns the number of falling edges waited until done is seen, or -1.
  task automatic wait_done(input int budget, output int n);
    n = -1;
    for (int i = 0; i < budget; i++) begin
      if (dif.done === 1'b1) begin
        n = i;
        break;
      end
      @(negedge clk);
    end
    if (n < 0) begin
      vectors++;
      miscompares++;
      $display("FAIL wait_done: no done within %0d cycles", budget);
    end
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin
    int n, dones;
    reset = 1'b1;
    dif.start = 1'b0;
    load('0, '0, '0, '0, '0);
    repeat (3) @(negedge clk);
    check("reset busy", {31'b0, dif.busy}, 32'd0);
    check("reset done", {31'b0, dif.done}, 32'd0);
    check("reset x_out", dif.x_out, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Basic run
    load(32'd0, 32'd0, 32'd1, 32'd2, 32'd1);
    go();
    wait_done(20, n);
    check("basic latency", n, 32'd3);
    check("basic x_out", dif.x_out, 32'd2);
    check("basic y_out", dif.y_out, 32'd2);
    check("basic u_out", dif.u_out, 32'hFFFF_FFFB);
    check("basic steps", {29'b0, dif.steps_out}, 32'd2);
    check("basic timeout", {31'b0, dif.timeout}, 32'd0);

    // Zero-step run, started in the previous done cycle
    load(32'd5, 32'd7, 32'd9, 32'd5, 32'd1);
    go();
    wait_done(20, n);
    check("zero latency", n, 32'd1);
    check("zero x_out", dif.x_out, 32'd5);
    check("zero y_out", dif.y_out, 32'd7);
    check("zero u_out", dif.u_out, 32'd9);
    check("zero steps", {29'b0, dif.steps_out}, 32'd0);
    @(negedge clk);

    // Iteration-limit timeout
    load(32'd0, 32'd0, 32'd3, 32'd10, 32'd0);
    go();
    wait_done(20, n);
    check("to steps", {29'b0, dif.steps_out}, 32'd4);
    check("to flag", {31'b0, dif.timeout}, 32'd1);
    check("to x_out", dif.x_out, 32'd0);
    check("to u_out", dif.u_out, 32'd3);
    @(negedge clk);

    // start held high through a whole run: exactly one done pulse
    load(32'd0, 32'd0, 32'd1, 32'd2, 32'd1);
    dif.start = 1'b1;
    dones = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (dif.done === 1'b1) begin
        dones++;
        break;
      end
    end
    dif.start = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (dif.done === 1'b1) dones++;
    end
    check("held start dones", dones, 32'd1);
    check("held start idle", {31'b0, dif.busy}, 32'd0);

    // start in the done cycle launches the next run at once
    load(32'd0, 32'd0, 32'd1, 32'd2, 32'd1);
    go();
    wait_done(20, n);
    load(32'd1, 32'd0, 32'd0, 32'd3, 32'd1);
    dif.start = 1'b1;
    @(negedge clk);
    dif.start = 1'b0;
    check("b2b busy", {31'b0, dif.busy}, 32'd1);
    wait_done(20, n);
    check("b2b x_out", dif.x_out, 32'd3);
    check("b2b steps", {29'b0, dif.steps_out}, 32'd2);
    @(negedge clk);

    // Reset in the second RUN cycle aborts with no done pulse
    load(32'd0, 32'd0, 32'd1, 32'd2, 32'd1);
    go();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort busy", {31'b0, dif.busy}, 32'd0);
    check("abort x_out", dif.x_out, 32'd0);
    check("abort steps", {29'b0, dif.steps_out}, 32'd0);
    dones = 0;
    repeat (6) begin
      @(negedge clk);
      if (dif.done === 1'b1) dones++;
    end
    check("abort no done", dones, 32'd0);

    // Signed versus unsigned termination compare
    load(32'hFFFF_FFFF, 32'd0, 32'd0, 32'd1, 32'd1);
    go();
    wait_done(20, n);
`ifdef DIFFEQ_SIGNED_COMPARE_EN
    check("signed steps", {29'b0, dif.steps_out}, 32'd2);
    check("signed x_out", dif.x_out, 32'd1);
`else
    check("unsigned steps", {29'b0, dif.steps_out}, 32'd0);
    check("unsigned x_out", dif.x_out, 32'hFFFF_FFFF);
`endif
    @(negedge clk);

    // Randomized runs, checked by the per-cycle compare
    for (int r = 0; r < 40; r++) begin
      load($urandom_range(0, 20), $urandom, $urandom, $urandom_range(0, 24),
           $urandom_range(0, 4));
      go();
      wait_done(MAX_STEPS + 10, n);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
